handshake_slave_rx: RTL and testbench

Synthesizable receiving end of the handshake interface: accepts beats from any handshake master, buffers them in a small FIFO, and presents them on a drain port for downstream logic. An optional pseudo-random throttle deasserts `ready` so upstream masters can be exercised against backpressure in hardware as well as in simulation. It sits at the slave end of a `handshake_if` link and replaces the behavioural slave wherever a real sink is needed.

---
 rtl/handshake_pkg.sv | 13 +
 rtl/handshake_if.sv | 13 +
 rtl/handshake_throttle_lfsr.sv | 23 ++
 rtl/handshake_slave_rx.sv | 92 +++++++++
 tb/tb_handshake_slave_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for handshake blocks: throttle LFSR constants and step function.
package handshake_pkg;

  localparam int                   LFSR_BITS         = 16;
  localparam logic [LFSR_BITS-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_BITS-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Fibonacci step: taps 16,14,13,11 feed back into bit 0 on a left shift.
  function automatic logic [LFSR_BITS-1:0] lfsr_next(input logic [LFSR_BITS-1:0] cur);
    return {cur[LFSR_BITS-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/handshake_if.sv
// Valid/ready beat link between one master and one slave.
interface handshake_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/handshake_throttle_lfsr.sv
// Free-running 16-bit LFSR; bit 0 is the pseudo-random "allow" used to throttle ready.
module handshake_throttle_lfsr
  import handshake_pkg::*;
#(
  parameter logic [LFSR_BITS-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic allow
);

  logic [LFSR_BITS-1:0] r_lfsr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= SEED;
    else     r_lfsr <= lfsr_next(r_lfsr);
  end

  assign allow = r_lfsr[0];

endmodule

// File: rtl/handshake_slave_rx.sv
// Handshake sink: buffers accepted beats in a FIFO and presents the head on a drain port,
// with optional LFSR throttling of upstream ready.
module handshake_slave_rx
  import handshake_pkg::*;
#(
  parameter int                   DATA_BITS    = 8,
  parameter int                   DEPTH        = 8,
  parameter bit                   ALWAYS_READY = 1'b1,
  parameter logic [LFSR_BITS-1:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  handshake_if.slave                   s,
  handshake_if.master                  m,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [31:0]                  beat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [31:0]          r_beat_count;
  logic [DATA_BITS-1:0] r_m_data;

  logic          w_allow;
  logic          w_full;
  logic          w_empty;
  logic          w_s_ready;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_rd_ptr_next;
  logic          w_head_is_new;

  handshake_throttle_lfsr #(
    .SEED (LFSR_SEED)
  ) u_throttle (
    .clk   (clk),
    .rst   (rst),
    .allow (w_allow)
  );

  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_s_ready = !w_full && (ALWAYS_READY || w_allow);
  assign w_push    = s.valid && w_s_ready;
  assign w_pop     = !w_empty && m.ready;

  assign w_rd_ptr_next = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
  // The entry being written this edge becomes the head only when it lands at the new read slot.
  assign w_head_is_new = w_push && (w_rd_ptr_next == r_wr_ptr);

  // NOTE: storage is deliberately not reset; pointers define which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_beat_count <= '0;
      r_m_data     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + PW'(1);
        r_beat_count <= r_beat_count + 32'd1;
      end
      r_rd_ptr <= w_rd_ptr_next;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_push || w_pop)
        r_m_data <= w_head_is_new ? s.data : r_mem[w_rd_ptr_next[AW-1:0]];
    end
  end

  assign s.ready    = w_s_ready;
  assign m.valid    = !w_empty;
  assign m.data     = r_m_data;
  assign level      = r_level;
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_handshake_slave_rx.sv
// Directed bench for handshake_slave_rx: one always-ready instance and one throttled instance.
module tb_handshake_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  level_a, level_t;
  logic [31:0] bc_a, bc_t;

  int n_checks = 0;
  int n_pass   = 0;

  handshake_if #(.DATA_BITS(8)) s_a ();
  handshake_if #(.DATA_BITS(8)) m_a ();
  handshake_if #(.DATA_BITS(8)) s_t ();
  handshake_if #(.DATA_BITS(8)) m_t ();

  handshake_slave_rx #(
    .DATA_BITS(8), .DEPTH(8), .ALWAYS_READY(1'b1), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(rst), .s(s_a), .m(m_a), .level(level_a), .beat_count(bc_a)
  );

  handshake_slave_rx #(
    .DATA_BITS(8), .DEPTH(8), .ALWAYS_READY(1'b0), .LFSR_SEED(16'hACE1)
  ) dut_t (
    .clk(clk), .rst(rst), .s(s_t), .m(m_t), .level(level_t), .beat_count(bc_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Push n beats start, start+1, ... into dut_a, one per cycle; FIFO must have room.
  task automatic fill_a(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      s_a.valid = 1'b1;
      s_a.data  = start + 8'(i);
      check("fill_ready", {31'd0, s_a.ready}, 32'd1);
      @(posedge clk); @(negedge clk);
    end
    s_a.valid = 1'b0;
  endtask

  // Drain dut_a with m_ready=1 and compare against exp_q; a pending upstream beat
  // is dropped from s_valid once it has been accepted.
  task automatic drain_a(input logic [7:0] exp_q[$], input string tag);
    int idx = 0;
    int cyc = 0;
    bit acc;
    m_a.ready = 1'b1;
    while (idx < exp_q.size() && cyc < 40) begin
      acc = s_a.valid && s_a.ready;
      if (m_a.valid) begin
        check(tag, {24'd0, m_a.data}, {24'd0, exp_q[idx]});
        idx++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
      if (acc) s_a.valid = 1'b0;
    end
    check({tag, "_count"}, idx, exp_q.size());
    m_a.ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp1 [3];
    logic [7:0] q [$];
    logic [7:0] beats_t [4];
    bit         rdy_tbl [13];
    int         tx_idx, rx_idx;

    s_a.valid = 1'b0; s_a.data = 8'h00; m_a.ready = 1'b0;
    s_t.valid = 1'b0; s_t.data = 8'h00; m_t.ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_s_ready_a", {31'd0, s_a.ready}, 32'd1);
    check("rst_m_valid_a", {31'd0, m_a.valid}, 32'd0);
    check("rst_m_data_a",  {24'd0, m_a.data},  32'd0);
    check("rst_level_a",   {28'd0, level_a},   32'd0);
    check("rst_bc_a",      bc_a,               32'd0);
    check("rst_s_ready_t", {31'd0, s_t.ready}, 32'd1);
    check("rst_lfsr_t",    {16'd0, dut_t.u_throttle.r_lfsr}, 32'h0000ACE1);

    // Back-to-back A1, B2, C3 with m_ready=1: each visible one cycle after acceptance
    exp1 = '{8'hA1, 8'hB2, 8'hC3};
    m_a.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_a.valid = 1'b1;
      s_a.data  = exp1[i];
      @(posedge clk); @(negedge clk);
      check("b2b_valid", {31'd0, m_a.valid}, 32'd1);
      check("b2b_data",  {24'd0, m_a.data},  {24'd0, exp1[i]});
      check("b2b_level", {28'd0, level_a},   32'd1);
    end
    s_a.valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_level_end", {28'd0, level_a},   32'd0);
    check("b2b_valid_end", {31'd0, m_a.valid}, 32'd0);
    check("b2b_bc",        bc_a,               32'd3);
    m_a.ready = 1'b0;

    // Fill 01..08, 09 held by master, then drain 01..09 (09 lands at the wrapped slot)
    fill_a(8'h01, 8);
    check("full_level",   {28'd0, level_a},   32'd8);
    check("full_s_ready", {31'd0, s_a.ready}, 32'd0);
    s_a.valid = 1'b1;
    s_a.data  = 8'h09;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    check("hold_level",   {28'd0, level_a},   32'd8);
    check("hold_s_ready", {31'd0, s_a.ready}, 32'd0);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    drain_a(q, "drain9");
    check("drain9_level", {28'd0, level_a}, 32'd0);
    check("drain9_bc",    bc_a,             32'd12);

    // Full FIFO: drain and offered push in the same cycle; push only lands next cycle
    fill_a(8'h10, 8);
    check("fp_level_full", {28'd0, level_a}, 32'd8);
    s_a.valid = 1'b1;
    s_a.data  = 8'hD4;
    m_a.ready = 1'b1;
    check("fp_ready_full", {31'd0, s_a.ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    m_a.ready = 1'b0;
    check("fp_level_after_drain", {28'd0, level_a},   32'd7);
    check("fp_ready_after_drain", {31'd0, s_a.ready}, 32'd1);
    check("fp_head",              {24'd0, m_a.data},  32'h11);
    @(posedge clk); @(negedge clk);
    s_a.valid = 1'b0;
    check("fp_level_refill", {28'd0, level_a}, 32'd8);
    q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hD4};
    drain_a(q, "fp_drain");
    check("fp_bc", bc_a, 32'd21);

    // Throttled instance: ready follows lfsr[0] from seed ACE1, never s_valid
    rdy_tbl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    beats_t = '{8'hAB, 8'hCD, 8'hEF, 8'h12};
    do_reset();
    m_t.ready = 1'b1;
    tx_idx = 0;
    rx_idx = 0;
    for (int k = 0; k < 13; k++) begin
      bit acc;
      s_t.valid = (k >= 1) && (tx_idx < 4);
      s_t.data  = (tx_idx < 4) ? beats_t[tx_idx] : 8'h00;
      check($sformatf("thr_ready_k%0d", k), {31'd0, s_t.ready}, {31'd0, rdy_tbl[k]});
      if (m_t.valid) begin
        if (rx_idx < 4) check("thr_rx", {24'd0, m_t.data}, {24'd0, beats_t[rx_idx]});
        rx_idx++;
      end
      acc = s_t.valid && s_t.ready;
      @(posedge clk); @(negedge clk);
      if (acc) tx_idx++;
    end
    s_t.valid = 1'b0;
    check("thr_rx_count", rx_idx, 32'd4);
    check("thr_bc",       bc_t,   32'd4);
    check("thr_level",    {28'd0, level_t}, 32'd0);

    // Reset mid-transfer with five beats buffered
    m_a.ready = 1'b0;
    fill_a(8'h30, 5);
    check("pre_rst_level", {28'd0, level_a}, 32'd5);
    s_a.valid = 1'b1;
    s_a.data  = 8'h99;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    s_a.valid = 1'b0;
    check("mid_rst_level",   {28'd0, level_a},   32'd0);
    check("mid_rst_m_valid", {31'd0, m_a.valid}, 32'd0);
    check("mid_rst_m_data",  {24'd0, m_a.data},  32'd0);
    check("mid_rst_bc",      bc_a,               32'd0);
    check("mid_rst_lfsr",    {16'd0, dut_t.u_throttle.r_lfsr}, 32'h0000ACE1);

    // beat_count wrap from all-ones
    force dut_a.r_beat_count = 32'hFFFF_FFFF;
    #1;
    release dut_a.r_beat_count;
    check("wrap_preload", bc_a, 32'hFFFF_FFFF);
    s_a.valid = 1'b1;
    s_a.data  = 8'h5A;
    @(posedge clk); @(negedge clk);
    s_a.valid = 1'b0;
    check("wrap_bc",    bc_a,             32'd0);
    check("wrap_level", {28'd0, level_a}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
